// File: rtl/quad_input_filter.sv
// quad_input_filter: synchronizes and debounces quadrature channels A/B before the decoder.
// Optional glitch counter: define QUAD_INPUT_FILTER_GLITCH_CNT_EN to add the glitch_cnt port.
module quad_input_filter #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W = 16
) (
    input  logic hwclk,
    input  logic reset,
    input  logic A,
    input  logic B,
    output logic a_out,
    output logic b_out,
    output logic chg,
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic dual_chg
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
    logic [1:0] s1, s2, diff, last, upd;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    assign diff = s2 ^ {b_out, a_out};
    assign last = {cnt_b == LAST, cnt_a == LAST};
    assign upd = diff & last;
    // two-flop synchronizer for the raw encoder channels, bit 0 = A, bit 1 = B
    always_ff @(posedge hwclk or negedge reset)
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {B, A};
            s2 <= s1;
        end
    // per-channel stability counters; an output flips only after STABLE_CNT disagreeing cycles
    always_ff @(posedge hwclk or negedge reset)
        if (!reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
            a_out <= 1'b0;
            b_out <= 1'b0;
            chg <= 1'b0;
            dual_chg <= 1'b0;
        end else begin
            cnt_a <= diff[0] && !last[0] ? cnt_a + CNT_W'(1) : '0;
            cnt_b <= diff[1] && !last[1] ? cnt_b + CNT_W'(1) : '0;
            a_out <= a_out ^ upd[0];
            b_out <= b_out ^ upd[1];
            chg <= |upd;
            dual_chg <= &upd;
        end
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
    logic [1:0] glt;
    logic [8:0] gsum;
    assign glt = ~diff & {cnt_b != '0, cnt_a != '0};
    assign gsum = {1'b0, glitch_cnt} + {8'd0, glt[0]} + {8'd0, glt[1]};
    // saturating count of pulses that died before the filter accepted them
    always_ff @(posedge hwclk or negedge reset)
        if (!reset)
            glitch_cnt <= '0;
        else
            glitch_cnt <= gsum > 9'd255 ? 8'd255 : gsum[7:0];
`endif
endmodule

// File: tb/tb_quad_input_filter.sv
// tb_quad_input_filter: directed checks of latency, rejection, reset abort and glitch counting.
module tb_quad_input_filter;
    logic hwclk = 1'b0;
    logic reset = 1'b0;
    logic A = 1'b1;
    logic B = 1'b1;
    logic a_out, b_out, chg, dual_chg;
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif
    int cmp = 0;
    int err = 0;

    always #5 hwclk = ~hwclk;

    quad_input_filter #(.STABLE_CNT(4), .CNT_W(16)) dut (
        .hwclk(hwclk),
        .reset(reset),
        .A(A),
        .B(B),
        .a_out(a_out),
        .b_out(b_out),
        .chg(chg),
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .dual_chg(dual_chg)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    function automatic logic [7:0] st();
        return {4'd0, dual_chg, chg, b_out, a_out};
    endfunction

    // input change made just before edge 1; outputs {b,a} move from pre to post after edge 6
    task automatic filt(input string tag, input logic [1:0] pre, input logic [1:0] post, input logic d);
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk({tag, " hold"}, st(), {6'd0, pre});
        end
        tick();
        chk({tag, " update"}, st(), {4'd0, d, 1'b1, post});
        tick();
        chk({tag, " pulse_end"}, st(), {6'd0, post});
    endtask

    initial begin
        repeat (2) tick();
        chk("in_reset", st(), 8'h00);
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        chk("glitch_reset", glitch_cnt, 8'd0);
`endif
        reset = 1'b1;
        filt("rst_release", 2'b00, 2'b11, 1'b1);
        A = 1'b0;
        filt("a_fall", 2'b11, 2'b10, 1'b0);
        A = 1'b1;
        filt("a_rise", 2'b10, 2'b11, 1'b0);
        // B starts falling while A is mid-count; each finishes on its own schedule
        A = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 2) B = 1'b0;
            chk("indep", st(), e <= 5 ? 8'h03 : e == 6 ? 8'h06 : e == 7 ? 8'h02 : e == 8 ? 8'h04 : 8'h00);
        end
        B = 1'b1;
        filt("b_rise", 2'b00, 2'b10, 1'b0);
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        chk("glitch_none", glitch_cnt, 8'd0);
`endif
        // three-cycle pulse is rejected
        A = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 3) A = 1'b0;
            chk("short3", st(), 8'h02);
        end
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        chk("glitch_one", glitch_cnt, 8'd1);
`endif
        // four-cycle pulse is accepted, then filtered back low
        A = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 4) A = 1'b0;
            chk("exact4", st(), {6'd0, e == 6 || e == 10, 1'b1, e >= 6 && e <= 9});
        end
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        chk("glitch_after4", glitch_cnt, 8'd1);
        for (int p = 0; p < 100; p++) begin
            A = 1'b1;
            tick();
            A = 1'b0;
            repeat (3) tick();
        end
        chk("glitch_101", glitch_cnt, 8'd101);
        A = 1'b1;
        B = 1'b0;
        tick();
        A = 1'b0;
        B = 1'b1;
        repeat (3) tick();
        chk("glitch_dual", glitch_cnt, 8'd103);
        chk("glitch_dual_out", st(), 8'h02);
        for (int p = 0; p < 200; p++) begin
            A = 1'b1;
            tick();
            A = 1'b0;
            repeat (3) tick();
        end
        chk("glitch_sat", glitch_cnt, 8'd255);
`endif
        // reset during a count discards all progress
        A = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("mid_reset", st(), 8'h00);
`ifdef QUAD_INPUT_FILTER_GLITCH_CNT_EN
        chk("mid_reset_glitch", glitch_cnt, 8'd0);
`endif
        reset = 1'b1;
        filt("after_reset", 2'b00, 2'b11, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/quad_input_filter.md
QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning the number of consecutive cycles a synchronized input must differ from its output before the output updates (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the filter counter width (must satisfy 2^CNT_W > STABLE_CNT).
REQ-003 SHALL have port hwclk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have ports A, B  input  1 each  raw, asynchronous encoder channels.
REQ-006 SHALL have ports a_out, b_out  output  1 each  synchronized, debounced channels for the downstream quadrature decoder.
REQ-007 SHALL have port chg  output  1  one-cycle pulse when a_out or b_out updates.
REQ-008 SHALL have port dual_chg  output  1  one-cycle pulse when a_out and b_out update on the same edge (illegal quadrature step).
REQ-009 SHALL have port glitch_cnt  output  8  count of rejected pulses (present only per REQ-024).

Function
REQ-010 SHALL pass each channel through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL keep one independent CNT_W-bit counter per channel.
REQ-012 SHALL, per channel on each edge: s2 == out -> counter <= 0; s2 != out and counter < STABLE_CNT-1 -> counter +1; s2 != out and counter == STABLE_CNT-1 -> out <= s2, counter <= 0.
REQ-013 SHALL give a total latency from a stable input change to output change of STABLE_CNT+2 rising edges, the edge that first samples the new level counting as edge 1.
REQ-014 SHALL reject any s2 pulse shorter than STABLE_CNT cycles (output unchanged) and accept one of exactly STABLE_CNT cycles.
REQ-015 SHALL register chg and dual_chg so they assert in the same cycle the outputs take their new values, each for exactly one cycle per update.
REQ-016 SHALL, with STABLE_CNT=1, update out on the first edge that sees s2 != out (no filtering beyond synchronization).
REQ-017 SHALL treat a channel toggling while the other channel's counter is mid-count as independent; no cross-channel reset of counters.
REQ-018 SHALL count a glitch when s2 returns equal to out while counter != 0 (per channel); both channels glitching on one edge adds 2.
REQ-019 SHALL saturate glitch_cnt at 255 (no wrap).

Reset
REQ-020 SHALL, while reset is low, asynchronously force s1, s2, a_out, b_out, chg and dual_chg to 0, both counters to 0, and glitch_cnt to 0.
REQ-021 SHALL, after reset deassertion with A or B held high, raise the corresponding output through the normal filter path (STABLE_CNT+2 edges), asserting chg once.
REQ-022 SHALL abort any in-progress count when reset asserts mid-filter; no partial state survives.

Configuration
REQ-023 SHALL use macro QUAD_INPUT_FILTER_GLITCH_CNT_EN to control the glitch counter.
REQ-024 SHALL, with the macro defined, implement REQ-018/REQ-019 and port glitch_cnt; without it, omit the port and all glitch-count logic, other behaviour identical.

Verification (STABLE_CNT=4)
REQ-025 SHALL cover: reset low, A=B=1 -> all outputs 0; release reset -> a_out=b_out=1 after edge 6, chg=1 and dual_chg=1 for one cycle on that edge.
REQ-026 SHALL cover: A 0->1 held -> a_out rises after edge 6, chg one cycle, dual_chg stays 0.
REQ-027 SHALL cover: A high for 3 cycles then low -> a_out stays 0, glitch_cnt=1 (macro on); A high exactly 4 cycles -> a_out rises then returns low after a further STABLE_CNT-cycle filter.
REQ-028 SHALL cover: 300 short A glitches -> glitch_cnt saturates at 255.
REQ-029 SHALL cover: A rises, reset pulsed low at edge 4 -> a_out remains 0 and counter restarts; after release a_out rises 6 edges later.
REQ-030 SHALL cover: build without QUAD_INPUT_FILTER_GLITCH_CNT_EN -> no glitch_cnt port, REQ-025/026/029 results unchanged.
